// File: rtl/adder_operand_seq.sv
// Register-file operand sequencer for a registered adder: fetches rs1/rs2 onto A/B,
// waits out the adder latency, then writes Sum back to rd and pulses done.
module adder_operand_seq #(
  parameter int DATA_W    = 8,
  parameter int NREG      = 4,
  parameter int ADDR_W    = 2,
  parameter int ADDER_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rd,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  input  logic [DATA_W-1:0] Sum,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = (ADDER_LAT < 2) ? 1 : $clog2(ADDER_LAT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-1:0]   rd_lat;
  logic [DATA_W-1:0]   regs [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      rd_lat <= '0;
      A      <= '0;
      B      <= '0;
      result <= '0;
      done   <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      done <= 1'b0;
      // The load is scheduled first so a same-index write-back below overrides it.
      if (ld_en) regs[ld_addr] <= ld_data;
      case (state)
        IDLE: begin
          if (start) begin
            rd_lat <= rd;
            A      <= regs[rs1];
            B      <= regs[rs2];
            cnt    <= CNT_W'(ADDER_LAT);
            state  <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= WB;
        end
        WB: begin
          regs[rd_lat] <= Sum;
          result       <= Sum;
          done         <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_data  = regs[dbg_addr];
  assign dbg_state = state;

endmodule

// File: tb/tb_adder_operand_seq.sv
// Bench for adder_operand_seq: registered-adder model, register-file reference model,
// directed scenarios followed by randomized operations.
module tb_adder_operand_seq;

  localparam int DW = 8;
  localparam int AW = 2;
  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          ld_en = 1'b0;
  logic [AW-1:0] rs1 = '0, rs2 = '0, rd = '0, ld_addr = '0, dbg_addr = '0;
  logic [DW-1:0] ld_data = '0;
  logic [DW-1:0] a, b, result, dbg_data;
  logic [DW-1:0] sum = '0;
  logic          busy, done;
  logic [1:0]    dbg_state;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] model [NR];
  logic [DW-1:0] exp_q [$];

  always #5 clk = ~clk;

  // External adder with one cycle of latency.
  always_ff @(posedge clk) sum <= a + b;

  adder_operand_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rs1(rs1), .rs2(rs2), .rd(rd),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .A(a), .B(b), .Sum(sum), .busy(busy), .done(done), .result(result),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NR; i++) begin
      dbg_addr = AW'(i);
      #1;
      check($sformatf("%s reg%0d", tag, i), dbg_data, model[i]);
    end
  endtask

  task automatic load(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = addr; ld_data = data;
    @(posedge clk);
    @(negedge clk);
    ld_en = 1'b0;
    model[addr] = data;
  endtask

  // mode 0: plain op; 1: extra start during WAIT (rd=1); 2: load on the write-back edge;
  // 3: load during WAIT; 4: load on the accept edge.
  task automatic op(input string tag, input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                    input logic [AW-1:0] d, input int mode,
                    input logic [AW-1:0] la, input logic [DW-1:0] lv);
    logic [DW-1:0] ea, eb;
    ea = model[s1];
    eb = model[s2];
    exp_q.push_back(ea + eb);
    @(negedge clk);
    start = 1'b1; rs1 = s1; rs2 = s2; rd = d;
    if (mode == 4) begin ld_en = 1'b1; ld_addr = la; ld_data = lv; end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; ld_en = 1'b0;
    check({tag, " A"}, a, ea);
    check({tag, " B"}, b, eb);
    check({tag, " busy1"}, DW'(busy), DW'(1));
    check({tag, " done1"}, DW'(done), DW'(0));
    if (mode == 1) begin
      start = 1'b1; rd = 2'd1; rs1 = AW'($urandom_range(0, NR - 1)); rs2 = AW'($urandom_range(0, NR - 1));
    end
    if (mode == 3) begin ld_en = 1'b1; ld_addr = la; ld_data = lv; end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; ld_en = 1'b0;
    check({tag, " busy2"}, DW'(busy), DW'(1));
    check({tag, " done2"}, DW'(done), DW'(0));
    check({tag, " A held"}, a, ea);
    check({tag, " B held"}, b, eb);
    if (mode == 2) begin ld_en = 1'b1; ld_addr = la; ld_data = lv; end
    @(posedge clk);
    @(negedge clk);
    ld_en = 1'b0;
    check({tag, " done3"}, DW'(done), DW'(1));
    check({tag, " busy3"}, DW'(busy), DW'(0));
    check({tag, " result"}, result, exp_q[0]);
    if (mode >= 2) model[la] = lv;
    model[d] = exp_q.pop_front();
    @(posedge clk);
    @(negedge clk);
    check({tag, " done4"}, DW'(done), DW'(0));
    check({tag, " busy4"}, DW'(busy), DW'(0));
    check_regs(tag);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " busy"}, DW'(busy), DW'(0));
    check({tag, " done"}, DW'(done), DW'(0));
    check({tag, " A"}, a, '0);
    check({tag, " B"}, b, '0);
    check({tag, " result"}, result, '0);
    check_regs(tag);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) model[i] = '0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    load(0, 8'h01); load(1, 8'h02);
    op("t1", 0, 1, 2, 0, 0, 0);
    check("t1 r2", model[2], 8'h03);

    load(0, 8'h03); load(1, 8'h04);
    op("t2", 0, 1, 0, 0, 0, 0);

    load(0, 8'hFF); load(1, 8'h02);
    op("t3", 0, 1, 3, 0, 0, 0);

    op("t4", 2, 3, 0, 1, 0, 0);
    op("t5same", 0, 1, 2, 2, 2, 8'hAA);
    op("t5other", 0, 1, 3, 2, 1, 8'h55);
    op("waitld", 0, 1, 2, 3, 0, 8'h77);
    op("acceptld", 1, 1, 1, 4, 1, 8'h10);

    // Reset in the middle of an operation.
    @(negedge clk);
    start = 1'b1; rs1 = 0; rs2 = 1; rd = 2;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) model[i] = '0;
    exp_q.delete();
    check_zero("t6");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t6 no done", DW'(done), DW'(0));
    end

    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 1) == 1)
        load(AW'($urandom_range(0, NR - 1)), DW'($urandom));
      op($sformatf("rnd%0d", n), AW'($urandom_range(0, NR - 1)), AW'($urandom_range(0, NR - 1)),
         AW'($urandom_range(0, NR - 1)), int'($urandom_range(0, 4)),
         AW'($urandom_range(0, NR - 1)), DW'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
